mips_multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. It is the producer of the 4-bit ALU

---
 rtl/mips_multicycle_ctrl_pkg.sv | 105 ++++++++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/mips_multicycle_ctrl.sv | 109 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU control codes, FSM states and the per-state control word.
package mips_multicycle_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int CTL_W   = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [CTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // wait_rdy marks FETCH, where the PC and IR writes wait on memory ready.
  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       wait_rdy;
    logic       decode;
  } ctl_t;

  function automatic ctl_t ctl_decode(input state_e st);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; c.wait_rdy = 1'b1; end
      S_DECODE:  begin c.alusrcb = 2'b11; c.decode = 1'b1; end
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: c.alusrca = 1'b1;
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:  begin c.alusrca = 1'b1; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] aluop_for(input state_e st);
    logic [1:0] op;
    case (st)
      S_EXECUTE: op = ALUOP_FUNCT;
      S_BRANCH:  op = ALUOP_SUB;
      default:   op = ALUOP_ADD;
    endcase
    return op;
  endfunction

  function automatic logic opcode_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decoder: ALUOP plus FUNCT selects the 4-bit ALU code.
module mips_multicycle_ctrl_alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [1:0]       aluop_i,
  input  logic [5:0]       funct_i,
  output logic [CTL_W-1:0] alu_ctl_o
);

  // Unknown FUNCT falls back to ADD; NAND is never produced.
  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_ctl_o = ALU_ADD;
      ALUOP_SUB: alu_ctl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctl_o = ALU_ADD;
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_NOR:  alu_ctl_o = ALU_NOR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      default: alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Control outputs are registered
// decodes of the next state; write enables are gated by reset and memory ready.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               zero_i,
  input  logic               mem_rdy_i,
  output logic [CTL_W-1:0]   alu_ctl_o,
  output logic               alusrca_o,
  output logic [1:0]         alusrcb_o,
  output logic [1:0]         pcsrc_o,
  output logic               pc_en_o,
  output logic               iord_o,
  output logic               memwrite_o,
  output logic               irwrite_o,
  output logic               regdst_o,
  output logic               memtoreg_o,
  output logic               regwrite_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  state_e           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic             rdy_ok;

  // Next-state logic; memory states hold until MEM_RDY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_rdy_i) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_i == OP_LW)      state_d = S_MEMRD;
        else if (opcode_i == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_rdy_i) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_rdy_i) state_d = S_FETCH;
        else           state_d = S_MEMWR;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  assign ctl_d = ctl_decode(state_d);

  mips_multicycle_ctrl_alu_decoder u_alu_decoder (
    .aluop_i   (aluop_for(state_d)),
    .funct_i   (funct_i),
    .alu_ctl_o (alu_ctl_d)
  );

  // State register with the control word for the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      ctl_q     <= ctl_decode(S_FETCH);
      alu_ctl_q <= ALU_ADD;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      alu_ctl_q <= alu_ctl_d;
    end
  end

  // A FETCH stall must not advance the PC or reload the IR.
  assign rdy_ok = ctl_q.wait_rdy ? mem_rdy_i : 1'b1;

  assign pc_en_o    = ~rst_i & ((ctl_q.pcwrite & rdy_ok) | (ctl_q.branch & zero_i));
  assign irwrite_o  = ~rst_i & ctl_q.irwrite & rdy_ok;
  assign memwrite_o = ~rst_i & ctl_q.memwrite;
  assign regwrite_o = ~rst_i & ctl_q.regwrite;
  assign illegal_o  = ~rst_i & ctl_q.decode & ~opcode_supported(opcode_i);

  assign alu_ctl_o  = alu_ctl_q;
  assign alusrca_o  = ctl_q.alusrca;
  assign alusrcb_o  = ctl_q.alusrcb;
  assign pcsrc_o    = ctl_q.pcsrc;
  assign iord_o     = ctl_q.iord;
  assign regdst_o   = ctl_q.regdst;
  assign memtoreg_o = ctl_q.memtoreg;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM with hand-computed expectations.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic [3:0] alu_ctl;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mips_multicycle_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .opcode_i   (opcode),
    .funct_i    (funct),
    .zero_i     (zero),
    .mem_rdy_i  (mem_rdy),
    .alu_ctl_o  (alu_ctl),
    .alusrca_o  (alusrca),
    .alusrcb_o  (alusrcb),
    .pcsrc_o    (pcsrc),
    .pc_en_o    (pc_en),
    .iord_o     (iord),
    .memwrite_o (memwrite),
    .irwrite_o  (irwrite),
    .regdst_o   (regdst),
    .memtoreg_o (memtoreg),
    .regwrite_o (regwrite),
    .illegal_o  (illegal),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [3:0] exp_ctl, input string tag);
    opcode = 6'h00; funct = fn;
    step(); check({tag, "_dec"}, 32'(state), 32'd1);
    step(); check({tag, "_exe"}, 32'(state), 32'd6);
    check({tag, "_ctl"}, 32'(alu_ctl), 32'(exp_ctl));
    step(); check({tag, "_wb_regwrite"}, 32'(regwrite), 32'd1);
    step(); check({tag, "_fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_rdy = 1'b1;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    rst = 1'b0; #1;
    check("fetch_pc_en", 32'(pc_en), 32'd1);
    check("fetch_irwrite", 32'(irwrite), 32'd1);
    check("fetch_alusrcb", 32'(alusrcb), 32'd1);

    // add: FETCH, DECODE, EXECUTE, ALUWB
    step(); check("add_dec", 32'(state), 32'd1);
    check("add_dec_alusrcb", 32'(alusrcb), 32'd3);
    check("add_dec_pc_en", 32'(pc_en), 32'd0);
    check("add_dec_illegal", 32'(illegal), 32'd0);
    step(); check("add_exe", 32'(state), 32'd6);
    check("add_exe_ctl", 32'(alu_ctl), 32'b0010);
    check("add_exe_alusrca", 32'(alusrca), 32'd1);
    check("add_exe_regwrite", 32'(regwrite), 32'd0);
    check("add_exe_regdst", 32'(regdst), 32'd0);
    step(); check("add_wb", 32'(state), 32'd7);
    check("add_wb_regwrite", 32'(regwrite), 32'd1);
    check("add_wb_regdst", 32'(regdst), 32'd1);
    step(); check("add_fetch", 32'(state), 32'd0);

    // beq with ZERO toggled inside BRANCH
    opcode = 6'h04;
    step(); step(); check("beq_state", 32'(state), 32'd8);
    zero = 1'b1; #1;
    check("beq_taken_pc_en", 32'(pc_en), 32'd1);
    check("beq_pcsrc", 32'(pcsrc), 32'd1);
    check("beq_ctl", 32'(alu_ctl), 32'b0110);
    zero = 1'b0; #1;
    check("beq_nt_pc_en", 32'(pc_en), 32'd0);
    step(); check("beq_fetch", 32'(state), 32'd0);

    // lw with two MEM_RDY=0 cycles in MEMRD: 7 cycles total
    opcode = 6'h23;
    step(); step(); check("lw_memadr", 32'(state), 32'd2);
    check("lw_memadr_alusrcb", 32'(alusrcb), 32'd2);
    mem_rdy = 1'b0;
    step(); check("lw_memrd1", 32'(state), 32'd3);
    check("lw_memrd_iord", 32'(iord), 32'd1);
    check("lw_memrd_regwrite", 32'(regwrite), 32'd0);
    step(); check("lw_memrd2", 32'(state), 32'd3);
    step(); check("lw_memrd3", 32'(state), 32'd3);
    check("lw_memrd3_regwrite", 32'(regwrite), 32'd0);
    mem_rdy = 1'b1;
    step(); check("lw_memwb", 32'(state), 32'd4);
    check("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
    check("lw_memwb_regwrite", 32'(regwrite), 32'd1);
    step(); check("lw_fetch", 32'(state), 32'd0);

    // FETCH stall for 3 cycles, then a single PC_EN pulse
    mem_rdy = 1'b0; opcode = 6'h3F; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_pc_en", 32'(pc_en), 32'd0);
      check("stall_irwrite", 32'(irwrite), 32'd0);
      check("stall_state", 32'(state), 32'd0);
      if (i < 2) step();
      else #1;
    end
    mem_rdy = 1'b1; #1;
    check("stall_release_pc_en", 32'(pc_en), 32'd1);
    check("stall_release_irwrite", 32'(irwrite), 32'd1);

    // illegal opcode: one-cycle pulse in DECODE, no writes
    step(); check("ill_dec", 32'(state), 32'd1);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_pc_en", 32'(pc_en), 32'd0);
    check("ill_regwrite", 32'(regwrite), 32'd0);
    check("ill_memwrite", 32'(memwrite), 32'd0);
    step(); check("ill_fetch", 32'(state), 32'd0);
    check("ill_gone", 32'(illegal), 32'd0);

    // FUNCT sweep, including an unknown funct that still writes back
    run_rtype(6'h24, 4'b0000, "and");
    run_rtype(6'h25, 4'b0001, "or");
    run_rtype(6'h27, 4'b1100, "nor");
    run_rtype(6'h2A, 4'b0111, "slt");
    run_rtype(6'h22, 4'b0110, "sub");
    run_rtype(6'h3F, 4'b0010, "unk");

    // addi and j
    opcode = 6'h08;
    step(); step(); check("addi_ex", 32'(state), 32'd9);
    check("addi_ex_alusrcb", 32'(alusrcb), 32'd2);
    step(); check("addi_wb", 32'(state), 32'd10);
    check("addi_wb_regwrite", 32'(regwrite), 32'd1);
    check("addi_wb_regdst", 32'(regdst), 32'd0);
    step(); check("addi_fetch", 32'(state), 32'd0);
    opcode = 6'h02;
    step(); step(); check("j_state", 32'(state), 32'd11);
    check("j_pcsrc", 32'(pcsrc), 32'd2);
    check("j_pc_en", 32'(pc_en), 32'd1);
    step(); check("j_fetch", 32'(state), 32'd0);

    // sw stalled in MEMWR, then reset mid-instruction
    opcode = 6'h2B;
    step(); step(); mem_rdy = 1'b0;
    step(); check("sw_memwr", 32'(state), 32'd5);
    check("sw_memwrite", 32'(memwrite), 32'd1);
    check("sw_iord", 32'(iord), 32'd1);
    step(); check("sw_memwrite_held", 32'(memwrite), 32'd1);
    rst = 1'b1; #1;
    check("sw_rst_memwrite", 32'(memwrite), 32'd0);
    check("sw_rst_pc_en", 32'(pc_en), 32'd0);
    step(); rst = 1'b0;
    step(); check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_memwrite", 32'(memwrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
